fibonacci_stream: RTL and testbench
===================================

FIBONACCI_STREAM -- requirements
Module: fibonacci_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning term width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of term-count and index fields.
REQ-003 SHALL have port clock_1  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a sequence; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous return to IDLE from any state.
REQ-007 SHALL have port seed_a  input  WIDTH  term 0, sampled when start is honoured.
REQ-008 SHALL have port seed_b  input  WIDTH  term 1, sampled when start is honoured.
REQ-009 SHALL have port len  input  LEN_W  number of terms to emit, sampled with start; 0 = unbounded.
REQ-010 SHALL have port ovf_stop  input  1  sampled with start; 1 = end sequence before the first unrepresentable term, 0 = wrap modulo 2^WIDTH.
REQ-011 SHALL have port f_ready  input  1  consumer accepts f_out this cycle.
REQ-012 SHALL have port f_valid  output  1  f_out holds a valid term.
REQ-013 SHALL have port f_out  output  WIDTH  current term.
REQ-014 SHALL have port f_index  output  LEN_W  index of current term, starting at 0.
REQ-015 SHALL have port overflow  output  1  sticky; set when a wrapped term is presented in wrap mode, or when a sequence ends on overflow in stop mode.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse at sequence end.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-019 IDLE: on start, SHALL load cur=seed_a, nxt=seed_b, nxt_ovf=0, index=0, clear overflow, latch len/ovf_stop, and enter RUN; f_valid rises the next cycle.
REQ-020 RUN: SHALL drive f_valid=1, f_out=cur, f_index=index.
REQ-021 Transfer occurs when f_valid && f_ready; without a transfer, f_out, f_index and all internal state SHALL hold unchanged (no term skipped or repeated).
REQ-022 On transfer: cur<=nxt, nxt<=(cur+nxt) mod 2^WIDTH, index<=index+1; the sum SHALL be computed at WIDTH+1 bits, and nxt_ovf<=carry | nxt_ovf (sticky).
REQ-023 Wrap mode: overflow SHALL set in the same edge that moves a term with nxt_ovf=1 into cur.
REQ-024 Stop mode: a transfer occurring while nxt_ovf=1 SHALL go to DONE instead of presenting nxt, and SHALL set overflow.
REQ-025 If len!=0, the transfer of the term with index len-1 SHALL go to DONE; if this coincides with REQ-024, the sequence SHALL end once, with overflow set.
REQ-026 DONE: SHALL assert done for exactly one cycle with f_valid=0, then enter IDLE; start is ignored in DONE.
REQ-027 abort SHALL take priority over start and transfer: next state IDLE, f_valid=0, no done pulse; overflow is held.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 Unbounded mode in wrap mode SHALL run indefinitely; index SHALL wrap modulo 2^LEN_W.
REQ-030 There SHALL be no combinational path from f_ready to f_valid or f_out.

Reset
REQ-031 Reset SHALL force, asynchronously: state=IDLE, f_valid=0, f_out=0, f_index=0, overflow=0, busy=0, done=0, cur=0, nxt=1, nxt_ovf=0.
REQ-032 Reset asserted mid-sequence SHALL discard the sequence; after release, outputs SHALL stay at reset values until the next start.

Structure
REQ-033 Package fib_pkg SHALL hold the state enum type and the default WIDTH/LEN_W constants.
REQ-034 No sub-module is needed; the adder and the FSM SHALL be in fibonacci_stream.

Verification
REQ-035 WIDTH=16, seeds 0/1, len=10, f_ready=1 -> f_out 0,1,1,2,3,5,8,13,21,34 on consecutive cycles, f_index 0..9, done pulse next cycle, overflow=0.
REQ-036 Same stimulus with f_ready low for 3 cycles while f_out=5 -> f_out=5 and f_index=5 held 3 cycles, then 8; sequence otherwise identical.
REQ-037 WIDTH=8, seeds 0/1, len=0, ovf_stop=1 -> last term 233 at index 13, then done pulse, overflow=1, f_valid=0.
REQ-038 WIDTH=8, seeds 0/1, len=0, ovf_stop=0 -> index 14 presents 121 (377 mod 256) and overflow rises with it; run continues.
REQ-039 Seeds 2/1 (Lucas), len=5 -> 2,1,3,4,7 then done; a start pulse during the run has no effect.
REQ-040 Assert reset mid-run at index 4 -> all outputs at reset values immediately; abort mid-run -> IDLE, no done pulse, next start restarts from index 0.

Source files
------------

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state type and default widths for the Fibonacci term streamer
package fib_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fib_state_e;
endpackage

// File: rtl/fibonacci_stream.sv
// rtl/fibonacci_stream.sv - streams Fibonacci-style terms with ready/valid handshake
module fibonacci_stream
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clock_1,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [LEN_W-1:0] len,
  input  logic             ovf_stop,
  input  logic             f_ready,
  output logic             f_valid,
  output logic [WIDTH-1:0] f_out,
  output logic [LEN_W-1:0] f_index,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             nxt_ovf_q, nxt_ovf_d;
  logic [LEN_W-1:0] index_q, index_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_stop_q, ovf_stop_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   sum;
  logic             last_term;

  assign sum       = {1'b0, cur_q} + {1'b0, nxt_q};
  assign last_term = (len_q != '0) && (index_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_ovf_d  = nxt_ovf_q;
    index_d    = index_q;
    len_d      = len_q;
    ovf_stop_d = ovf_stop_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_RUN;
          cur_d      = seed_a;
          nxt_d      = seed_b;
          nxt_ovf_d  = 1'b0;
          index_d    = '0;
          len_d      = len;
          ovf_stop_d = ovf_stop;
          overflow_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (f_ready) begin
          // Stop mode ends before presenting a wrapped term; this wins over a coincident length end.
          if (ovf_stop_q && nxt_ovf_q) begin
            state_d    = ST_DONE;
            overflow_d = 1'b1;
          end else if (last_term) begin
            state_d = ST_DONE;
          end else begin
            cur_d     = nxt_q;
            nxt_d     = sum[WIDTH-1:0];
            nxt_ovf_d = sum[WIDTH] | nxt_ovf_q;
            index_d   = index_q + LEN_W'(1);
            if (nxt_ovf_q) overflow_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      nxt_q      <= WIDTH'(1);
      nxt_ovf_q  <= 1'b0;
      index_q    <= '0;
      len_q      <= '0;
      ovf_stop_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_ovf_q  <= nxt_ovf_d;
      index_q    <= index_d;
      len_q      <= len_d;
      ovf_stop_q <= ovf_stop_d;
      overflow_q <= overflow_d;
    end
  end

  // Every output is a decode of registered state, so f_ready never reaches them combinationally.
  assign f_valid  = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign f_out    = cur_q;
  assign f_index  = index_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fibonacci_stream.sv
// tb/tb_fibonacci_stream.sv - directed self-checking bench for fibonacci_stream
module tb_fibonacci_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        a_start = 1'b0, a_abort = 1'b0, a_ovf_stop = 1'b0, a_ready = 1'b1;
  logic [15:0] a_seed_a = '0, a_seed_b = '0, a_len = '0;
  logic        a_valid, a_ovf, a_busy, a_done;
  logic [15:0] a_out, a_index;

  logic        b_start = 1'b0, b_abort = 1'b0, b_ovf_stop = 1'b0, b_ready = 1'b1;
  logic [7:0]  b_seed_a = '0, b_seed_b = '0;
  logic [15:0] b_len = '0;
  logic        b_valid, b_ovf, b_busy, b_done;
  logic [7:0]  b_out;
  logic [15:0] b_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fibonacci_stream #(.WIDTH(16), .LEN_W(16)) dut16 (
    .clock_1(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .seed_a(a_seed_a), .seed_b(a_seed_b), .len(a_len), .ovf_stop(a_ovf_stop),
    .f_ready(a_ready), .f_valid(a_valid), .f_out(a_out), .f_index(a_index),
    .overflow(a_ovf), .busy(a_busy), .done(a_done)
  );

  fibonacci_stream #(.WIDTH(8), .LEN_W(16)) dut8 (
    .clock_1(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .seed_a(b_seed_a), .seed_b(b_seed_b), .len(b_len), .ovf_stop(b_ovf_stop),
    .f_ready(b_ready), .f_valid(b_valid), .f_out(b_out), .f_index(b_index),
    .overflow(b_ovf), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fib16[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
  int fib8[14]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
  int lucas[5]  = '{2, 1, 3, 4, 7};

  initial begin
    #2;
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_out", 32'(a_out), 0);
    chk("rst_index", 32'(a_index), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_valid", 32'(a_valid), 0);

    // basic 16-bit sequence, len 10
    a_seed_a = 16'd0; a_seed_b = 16'd1; a_len = 16'd10; a_ovf_stop = 1'b0; a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("a_valid", 32'(a_valid), 1);
      chk("a_out", 32'(a_out), 32'(fib16[i]));
      chk("a_index", 32'(a_index), 32'(i));
      tick();
    end
    chk("a_done", 32'(a_done), 1);
    chk("a_done_valid", 32'(a_valid), 0);
    chk("a_ovf", 32'(a_ovf), 0);
    tick();
    chk("a_done_pulse", 32'(a_done), 0);
    chk("a_busy_after", 32'(a_busy), 0);

    // same with a 3-cycle stall on term 5
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("s_out", 32'(a_out), 32'(fib16[i]));
      chk("s_index", 32'(a_index), 32'(i));
      if (i == 5) begin
        a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("s_hold_out", 32'(a_out), 5);
          chk("s_hold_index", 32'(a_index), 5);
          chk("s_hold_valid", 32'(a_valid), 1);
        end
        a_ready = 1'b1;
      end
      tick();
    end
    chk("s_done", 32'(a_done), 1);
    chk("s_ovf", 32'(a_ovf), 0);
    tick();

    // 8-bit stop-on-overflow, unbounded
    b_seed_a = 8'd0; b_seed_b = 8'd1; b_len = 16'd0; b_ovf_stop = 1'b1; b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("st_out", 32'(b_out), 32'(fib8[i]));
      chk("st_index", 32'(b_index), 32'(i));
      tick();
    end
    chk("st_done", 32'(b_done), 1);
    chk("st_ovf", 32'(b_ovf), 1);
    chk("st_valid", 32'(b_valid), 0);
    tick();
    chk("st_done_pulse", 32'(b_done), 0);

    // 8-bit wrap mode, unbounded, then abort
    b_ovf_stop = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("wr_ovf_cleared", 32'(b_ovf), 0);
    for (int i = 0; i < 14; i++) tick();
    chk("wr_index14", 32'(b_index), 14);
    chk("wr_out14", 32'(b_out), 121);
    chk("wr_ovf14", 32'(b_ovf), 1);
    chk("wr_valid14", 32'(b_valid), 1);
    tick();
    chk("wr_out15", 32'(b_out), 98);
    chk("wr_busy15", 32'(b_busy), 1);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    chk("wr_abort_valid", 32'(b_valid), 0);
    chk("wr_abort_done", 32'(b_done), 0);
    chk("wr_abort_ovf", 32'(b_ovf), 1);
    tick();
    chk("wr_abort_done2", 32'(b_done), 0);

    // Lucas seeds with a stray start mid-run
    a_seed_a = 16'd2; a_seed_b = 16'd1; a_len = 16'd5;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("lu_out", 32'(a_out), 32'(lucas[i]));
      chk("lu_index", 32'(a_index), 32'(i));
      a_start = (i == 2);
      tick();
    end
    a_start = 1'b0;
    chk("lu_done", 32'(a_done), 1);
    tick();
    chk("lu_idle", 32'(a_valid), 0);

    // asynchronous reset mid-run at index 4
    a_seed_a = 16'd0; a_seed_b = 16'd1; a_len = 16'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rr_index4", 32'(a_index), 4);
    chk("rr_out4", 32'(a_out), 3);
    reset = 1'b1;
    #1;
    chk("rr_valid", 32'(a_valid), 0);
    chk("rr_out", 32'(a_out), 0);
    chk("rr_index", 32'(a_index), 0);
    chk("rr_busy", 32'(a_busy), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rr_post_valid", 32'(a_valid), 0);
    chk("rr_post_out", 32'(a_out), 0);

    // abort mid-run, then restart from index 0
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("ab_index2", 32'(a_index), 2);
    a_abort = 1'b1;
    a_start = 1'b1;
    tick();
    a_abort = 1'b0;
    a_start = 1'b0;
    chk("ab_valid", 32'(a_valid), 0);
    chk("ab_done", 32'(a_done), 0);
    tick();
    chk("ab_done2", 32'(a_done), 0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("ab_restart_index", 32'(a_index), 0);
    chk("ab_restart_out", 32'(a_out), 0);
    chk("ab_restart_valid", 32'(a_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
